// File: rtl/ysyx_22040127_ifu_pkg.sv
// Shared constants and helpers for the decoupled instruction-fetch unit.
package ysyx_22040127_ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC   = 32'h8000_0000;
  localparam int unsigned IF_TO_ID_WIDTH = 64;

  // Payload handed to decode: instruction in the upper word, its PC below.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } if_to_id_t;

  // Pick the 32-bit instruction out of an aligned doubleword by PC bit 2.
  function automatic logic [31:0] select_inst(input logic hi, input logic [63:0] data);
    return hi ? data[63:32] : data[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22040127_sync_fifo.sv
// Synchronous FIFO with clear; accepts a push when full if a pop happens in the same cycle.
module ysyx_22040127_sync_fifo
  import ysyx_22040127_ifu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  // Status flags and qualified push/pop strobes.
  always_comb begin
    full    = (32'(count) == DEPTH);
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping; clear wins over any same-cycle push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ysyx_22040127_ifu.sv
// Decoupled IF stage: owns the fetch PC, issues in-order memory requests,
// pairs responses with their PCs and buffers them for decode.
module ysyx_22040127_ifu
  import ysyx_22040127_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = IFU_RESET_PC,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [31:0]               imem_req_addr,
  input  logic                      imem_resp_valid,
  input  logic [63:0]               imem_resp_data,
  input  logic                      id_allowin,
  output logic                      if_to_id_valid,
  output logic [IF_TO_ID_WIDTH-1:0] if_to_id_bus,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  input  logic                      flush_valid,
  input  logic [31:0]               flush_pc,
  output logic [31:0]               if_pc
);

  localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]    fetch_pc;
  logic [OW-1:0]  outstanding;
  logic [OW-1:0]  drop_cnt;
  logic [OW-1:0]  out_next;
  logic           armed;
  logic           fire;
  logic           resp;
  logic           resp_keep;
  logic           redir;
  logic [31:0]    target;
  logic           fifo_pop;
  if_to_id_t      fifo_in;
  logic [63:0]    fifo_head;
  logic [FCW-1:0] fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  logic [31:0]    pcq_head;
  logic [OW-1:0]  pcq_count;
  logic           pcq_full;
  logic           pcq_empty;

  // Issue gating, response qualification and decode-side outputs.
  always_comb begin
    redir     = redirect_valid || flush_valid;
    target    = flush_valid ? flush_pc : redirect_pc;
    // Live (non-dropped) requests plus buffered entries must fit in the FIFO.
    imem_req_valid = rst
                     && (32'(outstanding - drop_cnt) + 32'(fifo_count) < FIFO_DEPTH)
                     && (32'(outstanding) < MAX_OUTSTANDING);
    fire      = imem_req_valid && imem_req_ready;
    resp      = imem_resp_valid && (outstanding != '0);
    resp_keep = resp && (drop_cnt == '0) && !redir;
    out_next  = outstanding + OW'(fire) - OW'(resp);
    if_to_id_valid = !fifo_empty && !redir;
    fifo_pop  = if_to_id_valid && id_allowin;
    fifo_in.inst = select_inst(pcq_head[2], imem_resp_data);
    fifo_in.pc   = pcq_head;
    if_to_id_bus = fifo_empty ? '0 : fifo_head;
    imem_req_addr = fetch_pc;
    if_pc         = fetch_pc;
  end

  // Fetch PC, outstanding-request counter and stale-response drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      armed       <= 1'b0;
    end else begin
      outstanding <= out_next;
      if (fire) armed <= 1'b1;
      if (redir) begin
        // Everything still in flight after this edge belongs to the old path.
        fetch_pc <= target;
        drop_cnt <= out_next;
      end else begin
        if (fire) fetch_pc <= fetch_pc + 32'd4;
        if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

  ysyx_22040127_sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (redir),
    .push      (fire),
    .push_data (fetch_pc),
    .pop       (resp_keep),
    .head      (pcq_head),
    .full      (pcq_full),
    .empty     (pcq_empty),
    .count     (pcq_count)
  );

  ysyx_22040127_sync_fifo #(
    .WIDTH (IF_TO_ID_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redir),
    .push      (resp_keep),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Protocol and bookkeeping invariants. The first request after reset arms
  // the response check so late responses to abandoned requests are tolerated.
  a_resp_outstanding: assert property (@(posedge clk) disable iff (!rst)
    (armed && imem_resp_valid) |-> (outstanding != '0));
  a_drop_bound: assert property (@(posedge clk) disable iff (!rst)
    drop_cnt <= outstanding);
  a_pcq_live: assert property (@(posedge clk) disable iff (!rst)
    pcq_count == outstanding - drop_cnt);
  a_pcq_room: assert property (@(posedge clk) disable iff (!rst)
    fire |-> !pcq_full);
  a_pcq_head: assert property (@(posedge clk) disable iff (!rst)
    resp_keep |-> !pcq_empty);
  a_fifo_room: assert property (@(posedge clk) disable iff (!rst)
    resp_keep |-> (!fifo_full || fifo_pop));

endmodule

// File: tb/tb_ysyx_22040127_ifu.sv
// Randomized bench for the fetch unit with a queue-based reference model.
module tb_ysyx_22040127_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int FD = 2;
  localparam int MO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [63:0] imem_resp_data = '0;
  logic        id_allowin = 1'b0;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_bus;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        flush_valid = 1'b0;
  logic [31:0] flush_pc = '0;
  logic [31:0] if_pc;

  ysyx_22040127_ifu #(
    .RESET_PC        (RST_PC),
    .FIFO_DEPTH      (FD),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .id_allowin      (id_allowin),
    .if_to_id_valid  (if_to_id_valid),
    .if_to_id_bus    (if_to_id_bus),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .flush_valid     (flush_valid),
    .flush_pc        (flush_pc),
    .if_pc           (if_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory image: the doubleword at an aligned address.
  function automatic logic [63:0] dw(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:3], 3'b000};
    return {b ^ 32'hA5A5_0004, b ^ 32'h1234_5678};
  endfunction

  // Memory environment: accepted request addresses awaiting a response.
  logic [31:0] mem_q[$];

  // Reference model: in-flight requests tagged stale when a redirect passes
  // them, and the list of instructions visible to decode.
  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } req_t;
  req_t        oq[$];
  logic [63:0] fq[$];
  logic [31:0] m_pc = RST_PC;
  int          m_live;
  bit          m_redir;
  bit          e_rv;
  bit          e_iv;
  req_t        m_e;

  // Compare DUT against the model each cycle, then advance model and memory.
  always @(negedge clk) begin
    if (!rst) begin
      oq.delete();
      fq.delete();
      m_pc = RST_PC;
    end else begin
      m_live = 0;
      foreach (oq[i]) if (!oq[i].stale) m_live++;
      m_redir = redirect_valid || flush_valid;
      e_rv = (m_live + fq.size() < FD) && (oq.size() < MO);
      e_iv = (fq.size() > 0) && !m_redir;
      chk("req_valid", imem_req_valid, e_rv);
      chk("if_pc", if_pc, m_pc);
      if (e_rv) chk("req_addr", imem_req_addr, m_pc);
      chk("if_to_id_valid", if_to_id_valid, e_iv);
      if (fq.size() > 0) chk("if_to_id_bus", if_to_id_bus, fq[0]);

      if (imem_req_valid && imem_req_ready) mem_q.push_back(imem_req_addr);
      if (imem_resp_valid && mem_q.size() > 0) void'(mem_q.pop_front());

      if (e_iv && id_allowin) void'(fq.pop_front());
      if (imem_resp_valid && oq.size() > 0) begin
        m_e = oq.pop_front();
        if (!m_e.stale && !m_redir)
          fq.push_back({m_e.pc[2] ? imem_resp_data[63:32] : imem_resp_data[31:0], m_e.pc});
      end
      if (e_rv && imem_req_ready) begin
        oq.push_back('{m_pc, m_redir});
        m_pc = m_pc + 32'd4;
      end
      if (m_redir) begin
        foreach (oq[i]) oq[i].stale = 1'b1;
        fq.delete();
        m_pc = flush_valid ? flush_pc : redirect_pc;
      end
    end
  end

  int rdy_pct   = 100;
  int resp_pct  = 100;
  int allow_pct = 100;
  int redir_pct = 0;
  int flush_pct = 0;

  task automatic drive();
    imem_req_ready  = ($urandom_range(0, 99) < rdy_pct);
    id_allowin      = ($urandom_range(0, 99) < allow_pct);
    imem_resp_valid = (mem_q.size() > 0) && ($urandom_range(0, 99) < resp_pct);
    imem_resp_data  = (mem_q.size() > 0) ? dw(mem_q[0]) : {$urandom, $urandom};
    redirect_valid  = ($urandom_range(0, 99) < redir_pct);
    flush_valid     = ($urandom_range(0, 99) < flush_pct);
    redirect_pc     = RST_PC + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    flush_pc        = RST_PC + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  bit seen;

  initial begin
    // Power-on reset.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_if_valid", if_to_id_valid, 1'b0);
    chk("rst_bus", if_to_id_bus, 64'd0);
    chk("rst_if_pc", if_pc, RST_PC);
    rst = 1'b1;
    drive();

    // Straight-line zero-wait fetch with literal expectations.
    for (int i = 0; i < 4; i++) begin
      at_neg();
      if (i == 0) begin
        chk("sl_req0_valid", imem_req_valid, 1'b1);
        chk("sl_req0_addr", imem_req_addr, 32'h8000_0000);
      end
      if (i == 1) chk("sl_req1_addr", imem_req_addr, 32'h8000_0004);
      if (i == 2) begin
        chk("sl_out0_valid", if_to_id_valid, 1'b1);
        chk("sl_out0_bus", if_to_id_bus, 64'h92345678_80000000);
      end
      if (i == 3) chk("sl_out1_bus", if_to_id_bus, 64'h25A50004_80000004);
      tick();
    end

    // Decode stalled for 10 cycles: FIFO fills and issue stops.
    allow_pct = 0;
    for (int i = 0; i < 10; i++) begin
      at_neg();
      tick();
    end
    at_neg();
    chk("stall_req_valid", imem_req_valid, 1'b0);
    chk("stall_if_valid", if_to_id_valid, 1'b1);
    allow_pct = 100;
    tick();

    // Build up two outstanding requests, then redirect.
    resp_pct = 0;
    for (int i = 0; i < 6; i++) begin
      at_neg();
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    imem_resp_valid = 1'b0;
    at_neg();
    chk("redir_if_valid", if_to_id_valid, 1'b0);
    resp_pct = 100;
    tick();
    at_neg();
    chk("redir_if_pc", if_pc, 32'h8000_0100);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      at_neg();
      if (imem_req_valid) begin
        seen = 1'b1;
        chk("redir_req_addr", imem_req_addr, 32'h8000_0100);
      end
    end
    if (!seen) chk("redir_req_timeout", 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (if_to_id_valid) begin
        seen = 1'b1;
        chk("redir_first_bus", if_to_id_bus, 64'h92345778_80000100);
      end else begin
        tick();
        at_neg();
      end
    end
    if (!seen) chk("redir_out_timeout", 1'b0, 1'b1);

    // Flush and redirect together: flush target wins.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    flush_valid    = 1'b1;
    flush_pc       = 32'h8000_0020;
    at_neg();
    tick();
    at_neg();
    chk("flush_prio_pc", if_pc, 32'h8000_0020);

    // Memory not ready: drain, then request must be held for 5 cycles.
    rdy_pct = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      at_neg();
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      at_neg();
      chk("hold_req_valid", imem_req_valid, 1'b1);
    end
    rdy_pct = 100;

    // Randomized traffic under varying rates.
    for (int blk = 0; blk < 30; blk++) begin
      rdy_pct   = $urandom_range(30, 100);
      resp_pct  = $urandom_range(20, 100);
      allow_pct = $urandom_range(20, 100);
      redir_pct = $urandom_range(0, 8);
      flush_pct = $urandom_range(0, 4);
      for (int i = 0; i < 100; i++) begin
        tick();
        at_neg();
      end
    end

    // Asynchronous reset with one request in flight.
    rdy_pct = 0; resp_pct = 100; allow_pct = 100; redir_pct = 0; flush_pct = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      at_neg();
    end
    tick();
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    at_neg();
    chk("ar_pre_req_valid", imem_req_valid, 1'b1);
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("ar_req_valid", imem_req_valid, 1'b0);
    chk("ar_if_valid", if_to_id_valid, 1'b0);
    chk("ar_bus", if_to_id_bus, 64'd0);
    chk("ar_if_pc", if_pc, RST_PC);
    for (int i = 0; i < 2; i++) begin
      tick();
      imem_req_ready = 1'b0;
      imem_resp_valid = 1'b0;
    end
    tick();
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_resp_valid = (mem_q.size() > 0);
    imem_resp_data = (mem_q.size() > 0) ? dw(mem_q[0]) : 64'd0;
    at_neg();
    chk("ar_late_if_valid", if_to_id_valid, 1'b0);
    tick();
    mem_q.delete();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    at_neg();
    chk("ar_late_ignored", if_to_id_valid, 1'b0);
    tick();
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    at_neg();
    chk("ar_first_valid", imem_req_valid, 1'b1);
    chk("ar_first_addr", imem_req_addr, 32'h8000_0000);
    rdy_pct = 100;
    for (int i = 0; i < 50; i++) begin
      tick();
      at_neg();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
